ram_arbiter_2r: RTL and testbench

Two-requester arbiter and sequencer in front of one single-port 1-cycle-read block RAM (64K x 32 data RAM: write-or-read per cycle, dout holds on write cycles). Requester 0 is the core data-memory port; requester 1 is the loader/UART path. Accepts one request at a time via valid/ready, drives the RAM port from registers, and returns read data or a write acknowledge to the requester that issued it.

---
 rtl/ram_arbiter_2r_if.sv | 41 ++++
 rtl/ram_arbiter_2r.sv | 118 +++++++++++
 tb/tb_ram_arbiter_2r.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_2r_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter_2r_if
// Brief    : Request/response bus of the two requesters plus the RAM port.
// Revision : 1.0
// ============================================================================
interface ram_arbiter_2r_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0]            req_we;
  logic [ADDR_WIDTH-1:0] req_addr0;
  logic [ADDR_WIDTH-1:0] req_addr1;
  logic [DATA_WIDTH-1:0] req_wdata0;
  logic [DATA_WIDTH-1:0] req_wdata1;
  logic [1:0]            rsp_rvalid;
  logic [DATA_WIDTH-1:0] rsp_rdata0;
  logic [DATA_WIDTH-1:0] rsp_rdata1;
  logic [1:0]            rsp_wack;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_di;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport slave (
    input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  ram_dout,
    output req_ready, rsp_rvalid, rsp_rdata0, rsp_rdata1, rsp_wack,
    output ram_we, ram_addr, ram_di
  );

  modport master (
    output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
    output ram_dout,
    input  req_ready, rsp_rvalid, rsp_rdata0, rsp_rdata1, rsp_wack,
    input  ram_we, ram_addr, ram_di
  );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter_2r.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter_2r
// Brief    : Two-requester arbiter/sequencer in front of a 1-cycle-read RAM.
// Revision : 1.0
// ============================================================================
module ram_arbiter_2r #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic            clk,
  input  logic            rstn,
  ram_arbiter_2r_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;

  logic [1:0]            r_state;
  logic                  r_last_grant;
  logic                  r_owner;
  logic                  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_di;
  logic [1:0]            r_rvalid;
  logic [1:0]            r_wack;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;

  logic [1:0]            w_grant;
  logic                  w_accept;
  logic                  w_win_id;
  logic                  w_win_we;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [DATA_WIDTH-1:0] w_win_wdata;

  always_comb begin
    w_grant = 2'b00;
    if (r_state == S_IDLE) begin
      case (bus.req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        // On a tie the requester that was not served last wins.
        2'b11:   w_grant = (FIXED_PRIORITY || r_last_grant) ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign w_accept    = |w_grant;
  assign w_win_id    = w_grant[1];
  assign w_win_we    = w_win_id ? bus.req_we[1]  : bus.req_we[0];
  assign w_win_addr  = w_win_id ? bus.req_addr1  : bus.req_addr0;
  assign w_win_wdata = w_win_id ? bus.req_wdata1 : bus.req_wdata0;

  // The RAM port is loaded on the accept edge so the access sits in ISSUE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_di     <= '0;
      r_rvalid     <= 2'b00;
      r_wack       <= 2'b00;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_ram_we <= 1'b0;
      r_rvalid <= 2'b00;
      r_wack   <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_owner      <= w_win_id;
            r_last_grant <= w_win_id;
            r_ram_we     <= w_win_we;
            r_ram_addr   <= w_win_addr;
            r_ram_di     <= w_win_wdata;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_ram_we) begin
            r_wack[r_owner] <= 1'b1;
            r_state         <= S_IDLE;
          end else begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (r_owner) begin
            r_rdata1 <= bus.ram_dout;
          end else begin
            r_rdata0 <= bus.ram_dout;
          end
          r_rvalid[r_owner] <= 1'b1;
          r_state           <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = w_grant;
  assign bus.rsp_rvalid = r_rvalid;
  assign bus.rsp_wack   = r_wack;
  assign bus.rsp_rdata0 = r_rdata0;
  assign bus.rsp_rdata1 = r_rdata1;
  assign bus.ram_we     = r_ram_we;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_di     = r_ram_di;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter_2r.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter_2r
// Brief    : Directed self-checking bench; dut_a round-robin, dut_b fixed.
// Revision : 1.0
// ============================================================================
module tb_ram_arbiter_2r;
  localparam int AW = 16;
  localparam int DW = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  ram_arbiter_2r_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  ram_arbiter_2r_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

  ram_arbiter_2r #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1'b0)) dut_a (
    .clk (clk),
    .rstn(rstn),
    .bus (bus_a)
  );

  ram_arbiter_2r #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1'b1)) dut_b (
    .clk (clk),
    .rstn(rstn),
    .bus (bus_b)
  );

  // Unwritten words read back as {C0DE, addr}; dout holds on write cycles.
  logic [DW-1:0] mem_a [0:255];
  logic [DW-1:0] mem_b [0:255];
  logic [255:0]  wr_a;
  logic [255:0]  wr_b;

  always @(posedge clk) begin
    if (!rstn) begin
      wr_a <= '0;
    end else if (bus_a.ram_we) begin
      mem_a[bus_a.ram_addr[7:0]] <= bus_a.ram_di;
      wr_a[bus_a.ram_addr[7:0]]  <= 1'b1;
    end else begin
      bus_a.ram_dout <= wr_a[bus_a.ram_addr[7:0]] ? mem_a[bus_a.ram_addr[7:0]]
                                                  : {16'hC0DE, bus_a.ram_addr};
    end
  end

  always @(posedge clk) begin
    if (!rstn) begin
      wr_b <= '0;
    end else if (bus_b.ram_we) begin
      mem_b[bus_b.ram_addr[7:0]] <= bus_b.ram_di;
      wr_b[bus_b.ram_addr[7:0]]  <= 1'b1;
    end else begin
      bus_b.ram_dout <= wr_b[bus_b.ram_addr[7:0]] ? mem_b[bus_b.ram_addr[7:0]]
                                                  : {16'hC0DE, bus_b.ram_addr};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] rr_rdy [12] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00,
                              2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
  logic [1:0] rr_rv  [13] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10,
                              2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
  logic [1:0] fp_rdy [12] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00,
                              2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
  logic [1:0] fp_rv  [13] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01,
                              2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};

  initial begin
    int         bad;
    logic [1:0] rv_seen;

    bus_a.req_valid = 2'b00; bus_a.req_we = 2'b00;
    bus_a.req_addr0 = '0;    bus_a.req_addr1 = '0;
    bus_a.req_wdata0 = '0;   bus_a.req_wdata1 = '0;
    bus_b.req_valid = 2'b00; bus_b.req_we = 2'b00;
    bus_b.req_addr0 = '0;    bus_b.req_addr1 = '0;
    bus_b.req_wdata0 = '0;   bus_b.req_wdata1 = '0;

    rstn = 1'b0;
    repeat (3) tick();
    chk("rst_state",  32'(dut_a.r_state),        32'd0);
    chk("rst_ram_we", 32'(bus_a.ram_we),         32'd0);
    chk("rst_addr",   32'(bus_a.ram_addr),       32'd0);
    chk("rst_di",     bus_a.ram_di,              32'd0);
    chk("rst_rvalid", 32'(bus_a.rsp_rvalid),     32'd0);
    chk("rst_wack",   32'(bus_a.rsp_wack),       32'd0);
    chk("rst_rdata1", bus_a.rsp_rdata1,          32'd0);
    rstn = 1'b1;
    tick();

    // Requester 0 writes 0x0010
    bus_a.req_valid = 2'b01; bus_a.req_we = 2'b01;
    bus_a.req_addr0 = 16'h0010; bus_a.req_wdata0 = 32'hDEADBEEF;
    #1;
    chk("wr_ready", 32'(bus_a.req_ready), 32'd1);
    tick();
    bus_a.req_valid = 2'b00; bus_a.req_we = 2'b00;
    #1;
    chk("wr_ram_we",   32'(bus_a.ram_we),   32'd1);
    chk("wr_ram_addr", 32'(bus_a.ram_addr), 32'h10);
    chk("wr_ram_di",   bus_a.ram_di,        32'hDEADBEEF);
    chk("wr_wack_t1",  32'(bus_a.rsp_wack), 32'd0);
    tick();
    chk("wr_wack_t2",  32'(bus_a.rsp_wack), 32'd1);
    chk("wr_we_t2",    32'(bus_a.ram_we),   32'd0);
    tick();
    chk("wr_wack_t3",  32'(bus_a.rsp_wack), 32'd0);

    // Requester 1 reads it back
    bus_a.req_valid = 2'b10; bus_a.req_addr1 = 16'h0010;
    #1;
    chk("rd_ready", 32'(bus_a.req_ready), 32'd2);
    tick();
    bus_a.req_valid = 2'b00;
    #1;
    chk("rd_ram_we",   32'(bus_a.ram_we),   32'd0);
    chk("rd_ram_addr", 32'(bus_a.ram_addr), 32'h10);
    tick();
    chk("rd_rv_t2", 32'(bus_a.rsp_rvalid), 32'd0);
    tick();
    chk("rd_rv_t3", 32'(bus_a.rsp_rvalid), 32'd2);
    chk("rd_data1", bus_a.rsp_rdata1,      32'hDEADBEEF);
    chk("rd_data0", bus_a.rsp_rdata0,      32'd0);
    tick();
    chk("rd_rv_t4", 32'(bus_a.rsp_rvalid), 32'd0);

    // Round-robin contention on dut_a
    bus_a.req_we = 2'b00; bus_a.req_addr0 = 16'h0001; bus_a.req_addr1 = 16'h0002;
    bus_a.req_valid = 2'b11;
    for (int c = 0; c < 13; c++) begin
      if (c == 12) bus_a.req_valid = 2'b00;
      #1;
      if (c < 12) chk($sformatf("rr_ready_c%0d", c), 32'(bus_a.req_ready), 32'(rr_rdy[c]));
      chk($sformatf("rr_rvalid_c%0d", c), 32'(bus_a.rsp_rvalid), 32'(rr_rv[c]));
      if (c == 3 || c == 9)  chk($sformatf("rr_rdata0_c%0d", c), bus_a.rsp_rdata0, 32'hC0DE0001);
      if (c == 6 || c == 12) chk($sformatf("rr_rdata1_c%0d", c), bus_a.rsp_rdata1, 32'hC0DE0002);
      tick();
    end

    // Fixed-priority contention on dut_b
    bus_b.req_we = 2'b00; bus_b.req_addr0 = 16'h0001; bus_b.req_addr1 = 16'h0002;
    bus_b.req_valid = 2'b11;
    for (int c = 0; c < 13; c++) begin
      if (c == 12) bus_b.req_valid = 2'b00;
      #1;
      if (c < 12) chk($sformatf("fp_ready_c%0d", c), 32'(bus_b.req_ready), 32'(fp_rdy[c]));
      chk($sformatf("fp_rvalid_c%0d", c), 32'(bus_b.rsp_rvalid), 32'(fp_rv[c]));
      if (c == 3 || c == 12) chk($sformatf("fp_rdata0_c%0d", c), bus_b.rsp_rdata0, 32'hC0DE0001);
      tick();
    end
    chk("fp_rdata1_never", bus_b.rsp_rdata1, 32'd0);

    // Reset during the DATA cycle of a requester-0 read
    bus_a.req_valid = 2'b01; bus_a.req_addr0 = 16'h0003;
    #1;
    chk("rst_mid_ready", 32'(bus_a.req_ready), 32'd1);
    tick();
    bus_a.req_valid = 2'b00;
    tick();
    chk("rst_mid_in_data", 32'(dut_a.r_state), 32'd2);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    #1;
    chk("rst_mid_rvalid", 32'(bus_a.rsp_rvalid), 32'd0);
    chk("rst_mid_state",  32'(dut_a.r_state),    32'd0);
    chk("rst_mid_rdata0", bus_a.rsp_rdata0,      32'd0);
    bus_a.req_valid = 2'b11; bus_a.req_addr0 = 16'h0004; bus_a.req_addr1 = 16'h0005;
    #1;
    chk("rst_mid_lastgrant", 32'(bus_a.req_ready), 32'd1);
    tick();
    bus_a.req_valid = 2'b00;
    tick();
    chk("post_rst_rv_t2", 32'(bus_a.rsp_rvalid), 32'd0);
    tick();
    chk("post_rst_rv_t3", 32'(bus_a.rsp_rvalid), 32'd1);
    chk("post_rst_rdata0", bus_a.rsp_rdata0,     32'hC0DE0004);
    tick();

    // Requester 0 withdraws a write while requester 1 is being served
    bus_a.req_valid = 2'b10; bus_a.req_we = 2'b00; bus_a.req_addr1 = 16'h0006;
    #1;
    chk("drop_ready_r1", 32'(bus_a.req_ready), 32'd2);
    tick();
    bus_a.req_valid = 2'b01; bus_a.req_we = 2'b01;
    bus_a.req_addr0 = 16'h0020; bus_a.req_wdata0 = 32'h12345678;
    #1;
    chk("drop_ready_busy", 32'(bus_a.req_ready), 32'd0);
    tick();
    bus_a.req_valid = 2'b00; bus_a.req_we = 2'b00;
    bad = 0;
    rv_seen = 2'b00;
    for (int k = 0; k < 7; k++) begin
      #1;
      if (bus_a.ram_we || bus_a.rsp_wack != 2'b00) bad++;
      rv_seen = rv_seen | bus_a.rsp_rvalid;
      tick();
    end
    chk("drop_no_access", 32'(bad),         32'd0);
    chk("drop_rv_owner",  32'(rv_seen),     32'd2);
    chk("drop_rdata1",    bus_a.rsp_rdata1, 32'hC0DE0006);
    bus_a.req_valid = 2'b10; bus_a.req_addr1 = 16'h0020;
    #1;
    tick();
    bus_a.req_valid = 2'b00;
    tick();
    tick();
    chk("drop_probe_rv",   32'(bus_a.rsp_rvalid), 32'd2);
    chk("drop_probe_data", bus_a.rsp_rdata1,      32'hC0DE0020);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
